// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM state encoding and a constant-safe clog2 for the disparity engine
package disp_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, COMPARE, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/disp_argmin.sv
// disp_argmin: masked THREADS-input minimum with lowest-index tie-break
// sads/valid: per-thread SAD and mask; min_sad/min_thread: winner; any_valid/any_zero: batch flags
module disp_argmin import disp_pkg::*; #(
  parameter int THREADS = 4,
  parameter int SAD_BITS = 16,
  parameter int TB = THREADS > 1 ? clog2(THREADS) : 1
) (
  input  logic [THREADS*SAD_BITS-1:0] sads,
  input  logic [THREADS-1:0]          valid,
  output logic [SAD_BITS-1:0]         min_sad,
  output logic [TB-1:0]               min_thread,
  output logic                        any_valid,
  output logic                        any_zero
);
  always_comb begin
    min_sad = '1;
    min_thread = '0;
    any_valid = 1'b0;
    any_zero = 1'b0;
    for (int t = 0; t < THREADS; t++)
      if (valid[t]) begin
        // strict compare keeps the earliest thread on ties
        if (!any_valid || sads[t*SAD_BITS +: SAD_BITS] < min_sad) begin
          min_sad = sads[t*SAD_BITS +: SAD_BITS];
          min_thread = TB'(t);
        end
        any_valid = 1'b1;
        any_zero = any_zero | (sads[t*SAD_BITS +: SAD_BITS] == '0);
      end
  end
endmodule

// File: rtl/disp_sad.sv
// disp_sad: combinational sum of absolute differences over one WIN x WIN window pair
// win_l/win_r: packed windows, pixel (r,c) at bit DATA_SIZE*(r*WIN+c); sad: window SAD
module disp_sad import disp_pkg::*; #(
  parameter int WIN = 15,
  parameter int DATA_SIZE = 8,
  parameter int SAD_BITS = clog2(WIN*WIN*(2**DATA_SIZE-1)+1)
) (
  input  logic [WIN*WIN*DATA_SIZE-1:0] win_l,
  input  logic [WIN*WIN*DATA_SIZE-1:0] win_r,
  output logic [SAD_BITS-1:0]          sad
);
  always_comb begin
    sad = '0;
    for (int i = 0; i < WIN*WIN; i++)
      sad = sad + SAD_BITS'(win_l[i*DATA_SIZE +: DATA_SIZE] > win_r[i*DATA_SIZE +: DATA_SIZE] ?
                            win_l[i*DATA_SIZE +: DATA_SIZE] - win_r[i*DATA_SIZE +: DATA_SIZE] :
                            win_r[i*DATA_SIZE +: DATA_SIZE] - win_l[i*DATA_SIZE +: DATA_SIZE]);
  end
endmodule

// File: rtl/disparity_engine_mt.sv
// disparity_engine_mt: handshaked block-matching disparity search, THREADS candidates per batch
// in_valid/in_ready + input_array_L/R + col_index: request; out_valid/out_ready + out_disp/out_sad: result
module disparity_engine_mt import disp_pkg::*; #(
  parameter int WIN = 15,
  parameter int DATA_SIZE = 8,
  parameter int IMG_W = 64,
  parameter int MAX_DISP = 64,
  parameter int THREADS = 4,
  parameter int EARLY_EXIT = 1,
  localparam int WIN_SIZE = WIN*WIN,
  localparam int SAD_BITS = clog2(WIN_SIZE*(2**DATA_SIZE-1)+1),
  localparam int DISP_BITS = clog2(MAX_DISP),
  localparam int COL_BITS = clog2(IMG_W),
  localparam int G = (MAX_DISP+THREADS-1)/THREADS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0]  input_array_L,
  input  logic [DATA_SIZE*IMG_W*WIN-1:0]  input_array_R,
  input  logic [COL_BITS-1:0]             col_index,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DISP_BITS-1:0]            out_disp,
  output logic [SAD_BITS-1:0]             out_sad
);
  localparam int AW = COL_BITS+DISP_BITS+1;
  localparam int BB = G > 1 ? clog2(G) : 1;
  localparam int TB = THREADS > 1 ? clog2(THREADS) : 1;
  localparam int PW = DATA_SIZE*IMG_W*WIN;
  localparam int WW = WIN_SIZE*DATA_SIZE;
  state_t state, nxt;
  logic started, accept, upd, finish, any_valid, any_zero;
  logic [PW-1:0] l_q, r_q;
  logic [COL_BITS-1:0] col_q;
  logic [BB-1:0] batch;
  logic [AW-1:0] base_d;
  logic [THREADS-1:0] valid;
  logic [WW-1:0] win_l;
  logic [THREADS*SAD_BITS-1:0] sad_w, sad_q;
  logic [SAD_BITS-1:0] best_sad, min_sad, nb_sad;
  logic [DISP_BITS-1:0] best_disp, nb_disp;
  logic [TB-1:0] min_thread;
  // masked candidates may point past the row; clamp keeps the mux in range
  function automatic int clamp_col(input logic [AW-1:0] x);
    return (x > AW'(IMG_W-1)) ? IMG_W-1 : int'(x);
  endfunction
  // started holds in_ready low until the first edge after reset release
  assign in_ready = started && state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign base_d = AW'(batch) * AW'(THREADS);
  always_comb begin
    win_l = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        win_l[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] =
          l_q[DATA_SIZE*(r*IMG_W+clamp_col(AW'(col_q)+AW'(c))) +: DATA_SIZE];
  end
  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    logic [AW-1:0] d_t;
    logic [WW-1:0] win_r;
    assign d_t = base_d + AW'(t);
    assign valid[t] = d_t < AW'(MAX_DISP) && AW'(col_q) + AW'(WIN-1) + d_t <= AW'(IMG_W-1);
    always_comb begin
      win_r = '0;
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          win_r[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] =
            r_q[DATA_SIZE*(r*IMG_W+clamp_col(AW'(col_q)+AW'(c)+d_t)) +: DATA_SIZE];
    end
    disp_sad #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .SAD_BITS(SAD_BITS)) u_sad (
      .win_l(win_l),
      .win_r(win_r),
      .sad(sad_w[t*SAD_BITS +: SAD_BITS])
    );
  end
  disp_argmin #(.THREADS(THREADS), .SAD_BITS(SAD_BITS), .TB(TB)) u_argmin (
    .sads(sad_q),
    .valid(valid),
    .min_sad(min_sad),
    .min_thread(min_thread),
    .any_valid(any_valid),
    .any_zero(any_zero)
  );
  // strict less-than lets earlier batches keep ties
  assign upd = any_valid && min_sad < best_sad;
  assign nb_sad = upd ? min_sad : best_sad;
  assign nb_disp = upd ? DISP_BITS'(base_d + AW'(min_thread)) : best_disp;
  assign finish = batch == BB'(G-1) || (EARLY_EXIT != 0 && any_zero);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? COMPUTE : IDLE;
      COMPUTE: nxt = COMPARE;
      COMPARE: nxt = finish ? DONE : COMPUTE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      started <= 1'b0;
      batch <= '0;
      best_sad <= '1;
      best_disp <= '0;
      out_disp <= '0;
      out_sad <= '0;
      sad_q <= '0;
    end else begin
      started <= 1'b1;
      if (accept) begin
        batch <= '0;
        best_sad <= '1;
        best_disp <= '0;
      end
      if (state == COMPUTE) sad_q <= sad_w;
      if (state == COMPARE) begin
        best_sad <= nb_sad;
        best_disp <= nb_disp;
        if (finish) begin
          out_disp <= nb_disp;
          out_sad <= nb_sad;
        end else batch <= batch + BB'(1);
      end
    end
  always_ff @(posedge clk)
    if (accept) begin
      l_q <= input_array_L;
      r_q <= input_array_R;
      col_q <= col_index;
    end
endmodule

// File: tb/tb_disparity_engine_mt.sv
// tb_disparity_engine_mt: directed checks of both early-exit variants against a brute-force search model
module tb_disparity_engine_mt;
  localparam int WIN = 3, DS = 4, IW = 16, MD = 8, TH = 4, G = 2;
  localparam int SB = 8, DB = 3, CB = 4, PW = DS*IW*WIN;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [CB-1:0] col = '0;
  logic [PW-1:0] arr_l, arr_r;
  logic ir1, ov1, ir0, ov0;
  logic [DB-1:0] od1, od0;
  logic [SB-1:0] os1, os0;
  int lp[WIN][IW], rp[WIN][IW];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, exp_disp = 0, exp_sad = 0;
  int lat_exp[2], res_cnt[2];
  bit pend[2], seen[2];
  int m_d, m_s, m_l1, m_l0;
  always #5 clk = ~clk;
  always_comb begin
    arr_l = '0;
    arr_r = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) begin
        arr_l[DS*(r*IW+c) +: DS] = DS'(lp[r][c]);
        arr_r[DS*(r*IW+c) +: DS] = DS'(rp[r][c]);
      end
  end
  disparity_engine_mt #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IW), .MAX_DISP(MD), .THREADS(TH), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .input_array_L(arr_l), .input_array_R(arr_r), .col_index(col),
    .out_valid(ov1), .out_ready(out_ready), .out_disp(od1), .out_sad(os1));
  disparity_engine_mt #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IW), .MAX_DISP(MD), .THREADS(TH), .EARLY_EXIT(0)) dut_ne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
    .input_array_L(arr_l), .input_array_R(arr_r), .col_index(col),
    .out_valid(ov0), .out_ready(out_ready), .out_disp(od0), .out_sad(os0));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input int c0, input int ee, output int disp, output int sad, output int lat);
    int s, zd, df;
    disp = 0;
    sad = (1 << SB) - 1;
    zd = -1;
    for (int d = 0; d < MD; d++)
      if (c0 + WIN - 1 + d <= IW - 1) begin
        s = 0;
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++) begin
            df = lp[r][c0+c] - rp[r][c0+c+d];
            s += df < 0 ? -df : df;
          end
        if (s < sad) begin
          sad = s;
          disp = d;
        end
        if (s == 0 && zd < 0) zd = d;
      end
    lat = (ee != 0 && zd >= 0) ? 2*(zd/TH+1) : 2*G;
  endtask
  task automatic mon(input int k, input logic v, input logic ir, input int od, input int os);
    if (v) begin
      if (!seen[k]) begin
        chk($sformatf("result_expected_%0d", k), int'(pend[k]), 1);
        chk($sformatf("latency_%0d", k), cyc - acc_cyc, lat_exp[k]);
        seen[k] = 1'b1;
        pend[k] = 1'b0;
        res_cnt[k]++;
      end
      chk($sformatf("out_disp_%0d", k), od, exp_disp);
      chk($sformatf("out_sad_%0d", k), os, exp_sad);
      chk($sformatf("in_ready_low_in_done_%0d", k), int'(ir), 0);
    end else seen[k] = 1'b0;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst_n) begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      seen[0] = 1'b0; seen[1] = 1'b0;
    end else begin
      mon(1, ov1, ir1, int'(od1), int'(os1));
      mon(0, ov0, ir0, int'(od0), int'(os0));
      if (in_valid && ir1 && ir0) begin
        model(int'(col), 1, m_d, m_s, m_l1);
        model(int'(col), 0, m_d, m_s, m_l0);
        exp_disp = m_d;
        exp_sad = m_s;
        lat_exp[1] = m_l1;
        lat_exp[0] = m_l0;
        acc_cyc = cyc + 1;
        pend[0] = 1'b1; pend[1] = 1'b1;
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int c0);
    int n;
    n = 0;
    while (!(ir1 && ir0) && n < 60) begin tick(); n++; end
    chk("send_ready", int'(ir1 && ir0), 1);
    col = CB'(c0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_both(input int r1, input int r0);
    int n;
    n = 0;
    while ((res_cnt[1] == r1 || res_cnt[0] == r0) && n < 60) begin tick(); n++; end
    chk("result_arrived", int'(res_cnt[1] != r1 && res_cnt[0] != r0), 1);
  endtask
  task automatic run(input int c0);
    int r1, r0;
    r1 = res_cnt[1];
    r0 = res_cnt[0];
    send(c0);
    wait_both(r1, r0);
    tick(); tick();
  endtask
  task automatic fill_shift(input int sh);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) lp[r][c] = int'($urandom_range(0, 15));
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) rp[r][c] = c >= sh ? lp[r][c-sh] : int'($urandom_range(0, 15));
  endtask
  task automatic fill_uniform(input int v);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) begin lp[r][c] = v; rp[r][c] = v; end
  endtask
  task automatic fill_cols(input int lo0, input int hi0, input int lo1, input int hi1);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < IW; c++) begin
        lp[r][c] = 0;
        rp[r][c] = ((c >= lo0 && c <= hi0) || (c >= lo1 && c <= hi1)) ? 1 : 5;
      end
  endtask
  task automatic fill_shift5();
    fill_shift(5);
    for (int d = 0; d < 5; d++) rp[0][d] = lp[0][0] ^ 8;
  endtask
  initial begin
    res_cnt[0] = 0; res_cnt[1] = 0;
    lat_exp[0] = 0; lat_exp[1] = 0;
    fill_uniform(0);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", int'(ir1 | ir0), 0);
      chk("rst_out_valid", int'(ov1 | ov0), 0);
      chk("rst_out_disp", int'(od1) + int'(od0), 0);
      chk("rst_out_sad", int'(os1) + int'(os0), 0);
    end
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", int'(ir1 | ir0), 0);
    tick();
    chk("in_ready_after_release", int'(ir1 & ir0), 1);
    fill_shift5();
    model(0, 1, m_d, m_s, m_l1);
    chk("pin_shift5_disp", m_d, 5);
    chk("pin_shift5_sad", m_s, 0);
    chk("pin_shift5_lat_ee", m_l1, 4);
    model(0, 0, m_d, m_s, m_l0);
    chk("pin_shift5_lat_full", m_l0, 4);
    run(0);
    fill_uniform(7);
    model(0, 1, m_d, m_s, m_l1);
    chk("pin_uniform_disp", m_d, 0);
    chk("pin_uniform_sad", m_s, 0);
    chk("pin_uniform_lat_ee", m_l1, 2);
    run(0);
    fill_shift(6);
    model(12, 1, m_d, m_s, m_l1);
    chk("pin_col12_disp_in_range", int'(m_d <= 1), 1);
    run(12);
    model(14, 1, m_d, m_s, m_l1);
    chk("pin_col14_disp", m_d, 0);
    chk("pin_col14_sad", m_s, 255);
    chk("pin_col14_lat", m_l1, 4);
    run(14);
    fill_cols(2, 4, 6, 8);
    model(0, 1, m_d, m_s, m_l1);
    chk("pin_tie_batches_disp", m_d, 2);
    chk("pin_tie_batches_sad", m_s, 9);
    run(0);
    fill_cols(4, 7, 4, 7);
    model(0, 1, m_d, m_s, m_l1);
    chk("pin_tie_threads_disp", m_d, 4);
    chk("pin_tie_threads_sad", m_s, 9);
    run(0);
    fill_shift5();
    out_ready = 1'b0;
    begin
      int r1, r0;
      r1 = res_cnt[1];
      r0 = res_cnt[0];
      send(0);
      wait_both(r1, r0);
      fill_uniform(3);
      col = '0;
      in_valid = 1'b1;
      repeat (10) begin
        tick();
        chk("bp_out_valid_held", int'(ov1 & ov0), 1);
        chk("bp_in_ready_low", int'(ir1 | ir0), 0);
      end
      r1 = res_cnt[1];
      r0 = res_cnt[0];
      out_ready = 1'b1;
      tick();
      chk("bp_release_out_valid", int'(ov1 | ov0), 0);
      chk("bp_release_in_ready", int'(ir1 & ir0), 1);
      tick();
      in_valid = 1'b0;
      chk("bp_next_accepted", int'(ir1 | ir0), 0);
      wait_both(r1, r0);
      tick(); tick();
    end
    fill_shift5();
    send(0);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", int'(ov1 | ov0), 0);
    chk("midrst_in_ready", int'(ir1 | ir0), 0);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      chk("midrst_no_result", int'(ov1 | ov0), 0);
    end
    chk("midrst_idle", int'(ir1 & ir0), 1);
    fill_shift(3);
    run(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/disparity_engine_mt.md
Name: disparity_engine_mt

Overview:
- Multi-threaded, handshaked successor to the single-SAD disparity FSM.
- Evaluates THREADS candidate disparities per batch, in parallel. Masks candidates that fall outside the image row. Returns the best (minimum-SAD) disparity and its SAD.
- Returns to IDLE after each result, so no reset is needed between pixels. Sits between the row-window buffer and the disparity-map writer.

Parameters:
- WIN, 15, window side (WIN x WIN block).
- DATA_SIZE, 8, pixel bits.
- IMG_W, 64, row-chunk width in pixels.
- MAX_DISP, 64, number of candidate disparities, 0..MAX_DISP-1.
- THREADS, 4, parallel SAD units; need not divide MAX_DISP.
- EARLY_EXIT, 1, 1 = stop after the first batch containing a valid SAD of 0.
- Derived (localparam): WIN_SIZE = WIN*WIN; SAD_BITS = clog2(WIN_SIZE*(2^DATA_SIZE-1)+1); DISP_BITS = clog2(MAX_DISP); COL_BITS = clog2(IMG_W); G = ceil(MAX_DISP/THREADS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- input_array_L  in  DATA_SIZE*IMG_W*WIN  left rows; pixel (r,c) at bit DATA_SIZE*(r*IMG_W+c).
- input_array_R  in  DATA_SIZE*IMG_W*WIN  right rows, same packing.
- col_index  in  COL_BITS  left-window start column.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_disp  out  DISP_BITS  best disparity.
- out_sad  out  SAD_BITS  SAD at out_disp; all-ones if no candidate was valid.

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n is low:
  - state = IDLE;
  - out_valid = 0, out_disp = 0, out_sad = 0;
  - in_ready = 0;
  - internal best_sad = all-ones.
- After reset: in_ready = 1 from the first clock edge after rst_n deasserts.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, register both arrays and col_index, set batch = 0, set best_sad = all-ones, go to COMPUTE. Inputs may change after acceptance.
  - COMPUTE: thread t evaluates d = batch*THREADS + t. The per-thread SAD is registered at the end of this cycle. Go to COMPARE.
  - COMPARE: reduce the registered SADs and update best_sad/best_disp. If last batch, or (EARLY_EXIT and a valid SAD == 0 in this batch), go to DONE. Otherwise increment batch and go to COMPUTE.
  - DONE: out_valid = 1 with out_disp/out_sad held stable; in_ready = 0. On out_ready, go to IDLE and drop out_valid.
- No same-cycle accept in DONE: the next request is accepted, at the earliest, one cycle after the result handshake.
- Candidate validity: d is valid iff d < MAX_DISP and col_index + WIN - 1 + d <= IMG_W - 1. Invalid threads are ignored in the reduction.
  - The window mux must never index outside the array; clamp the index, the value is don't-care when masked.
- Reduction and ties:
  - Update only on strict SAD < best_sad, so earlier batches win ties.
  - Within a batch, the lowest thread index wins ties.
  - Net effect: the lowest disparity wins any tie.
- Widths: absolute difference is unsigned, DATA_SIZE bits. Accumulation uses SAD_BITS with no overflow. Disparity arithmetic uses COL_BITS+DISP_BITS+1 bits to avoid wrap.
- No valid candidate (col_index + WIN > IMG_W): run all G batches, then report out_disp = 0, out_sad = all-ones.
- Latency: out_valid rises 2*(b+1) cycles after the accepting edge, where b = last batch executed. Full search: 2G cycles (32 at defaults).
- Back-pressure: while out_valid & !out_ready, all outputs are stable and in_valid is ignored.
- Reset mid-operation: abort immediately to the reset values above; no result is emitted.

Decomposition:
- Package disp_pkg: state encoding (IDLE, COMPUTE, COMPARE, DONE) and a clog2 helper function.
- Per-thread SAD: instantiate the existing SAD module THREADS times.
- New sub-module disp_argmin: combinational THREADS-input masked min-reduction with a lowest-index tie-break. Outputs min_sad, min_thread, any_valid, any_zero.

Test Plan:
Bench parameters: WIN=3, IMG_W=16, MAX_DISP=8, THREADS=4, so G=2.
1. rst_n low 3 cycles, then high -> in_ready=0, out_valid=0 and out_disp=out_sad=0 during reset; in_ready=1 the cycle after release.
2. Random L; R(r,c+5)=L(r,c); col_index=0; EARLY_EXIT=1 -> out_disp=5, out_sad=0, out_valid 4 cycles after accept. Same with EARLY_EXIT=0 -> identical result, 4 cycles.
3. Uniform L=R=7 -> out_disp=0, out_sad=0, out_valid 2 cycles after accept (early exit in batch 0).
4. col_index=12, true match at d=6 -> only d in {0,1} valid; result is the argmin over {0,1}, never 6. col_index=14 -> out_disp=0, out_sad=0xFF after 4 cycles (SAD_BITS=8 at bench parameters).
5. Equal minimum SAD=9 at d=2 and d=6 -> out_disp=2, out_sad=9. Equal minimum at d=4 and d=5 (same batch) -> out_disp=4.
6. Hold out_ready=0 for 10 cycles with in_valid=1 -> outputs stable, in_ready=0, no accept; then out_ready=1 -> IDLE, next request accepted one cycle later. Separately, pulse rst_n low during COMPUTE -> out_valid never asserts; engine back in IDLE.
